pvp_match_tracker: RTL and testbench

- Scores a multi-round 1v1 match. Sits between the PVP grid game logic (upstream) and the screen state controller (downstream).
- Consumes per-round results from the grid logic, accumulates scores and decides the match winner.
- Drives pvp_game_status (current-round result) and pvp_game_status_final (match result) to the screen state controller.
- Sequence it supports: round over -> PVP_RESULT, then either the next round or PVP_FINAL.

---
 rtl/pvp_match_tracker_if.sv | 29 ++
 rtl/pvp_match_tracker.sv | 125 ++++++++++++
 tb/tb_pvp_match_tracker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pvp_match_tracker_if.sv
// Round-result and score bus between the grid logic, the match tracker
// and the screen state controller.
interface pvp_match_tracker_if #(
    parameter int SCORE_W = 3
);
    logic               grid_reset_flag;
    logic               round_valid;
    logic [1:0]         round_winner;
    logic [1:0]         pvp_game_status;
    logic [1:0]         pvp_game_status_final;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [SCORE_W-1:0] round_num;
    logic               match_point;

    // Drives round results and new-round strobes, observes the scoreboard
    modport master (
        output grid_reset_flag, round_valid, round_winner,
        input  pvp_game_status, pvp_game_status_final,
        input  p1_score, p2_score, round_num, match_point
    );

    // The tracker itself
    modport slave (
        input  grid_reset_flag, round_valid, round_winner,
        output pvp_game_status, pvp_game_status_final,
        output p1_score, p2_score, round_num, match_point
    );
endinterface

// File: rtl/pvp_match_tracker.sv
// Multi-round 1v1 match scorer: accumulates round wins, reports the current
// round result and decides the match winner on the same edge.
module pvp_match_tracker #(
    parameter int WINS_TO_MATCH = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int SCORE_W       = 3
) (
    input  logic                clk,
    input  logic                general_reset,
    pvp_match_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        ROUND_ACTIVE = 2'd0,
        ROUND_DONE   = 2'd1,
        MATCH_DONE   = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] CNT_MAX   = '1;
    localparam logic [SCORE_W-1:0] WIN_CNT   = SCORE_W'(WINS_TO_MATCH);
    localparam logic [SCORE_W-1:0] POINT_CNT = SCORE_W'(WINS_TO_MATCH - 1);
    localparam logic [SCORE_W-1:0] ROUND_CAP = SCORE_W'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic [1:0]         status_q, status_d;
    logic [1:0]         final_q, final_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [SCORE_W-1:0] round_q, round_d;

    logic [SCORE_W-1:0] p1_new, p2_new, round_new;

    // State and scoreboard registers, cleared asynchronously outside PVP
    always_ff @(posedge clk or posedge general_reset) begin
        if (general_reset) begin
            state_q  <= ROUND_ACTIVE;
            status_q <= 2'b00;
            final_q  <= 2'b00;
            p1_q     <= '0;
            p2_q     <= '0;
            round_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            final_q  <= final_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            round_q  <= round_d;
        end
    end

    // Next state; the match is judged on post-increment counts so the final
    // result never lags the round result
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        final_d  = final_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        round_d  = round_q;

        p1_new    = p1_q;
        p2_new    = p2_q;
        round_new = (round_q == CNT_MAX) ? round_q : round_q + SCORE_W'(1);
        if (bus.round_winner == 2'b01 && p1_q != CNT_MAX) begin
            p1_new = p1_q + SCORE_W'(1);
        end
        if (bus.round_winner == 2'b10 && p2_q != CNT_MAX) begin
            p2_new = p2_q + SCORE_W'(1);
        end

        unique case (state_q)
            ROUND_ACTIVE: begin
                if (!bus.grid_reset_flag && bus.round_valid &&
                    bus.round_winner != 2'b00) begin
                    status_d = bus.round_winner;
                    p1_d     = p1_new;
                    p2_d     = p2_new;
                    round_d  = round_new;
                    if (bus.round_winner == 2'b01 && p1_new == WIN_CNT) begin
                        final_d = 2'b01;
                        state_d = MATCH_DONE;
                    end else if (bus.round_winner == 2'b10 && p2_new == WIN_CNT) begin
                        final_d = 2'b10;
                        state_d = MATCH_DONE;
                    end else if (round_new == ROUND_CAP) begin
                        if (p1_new > p2_new) begin
                            final_d = 2'b01;
                        end else if (p2_new > p1_new) begin
                            final_d = 2'b10;
                        end else begin
                            final_d = 2'b11;
                        end
                        state_d = MATCH_DONE;
                    end else begin
                        state_d = ROUND_DONE;
                    end
                end
            end
            ROUND_DONE: begin
                if (bus.grid_reset_flag) begin
                    status_d = 2'b00;
                    state_d  = ROUND_ACTIVE;
                end
            end
            MATCH_DONE: begin
            end
            default: begin
                state_d = ROUND_ACTIVE;
            end
        endcase
    end

    // Registered scoreboard out; match point gated so it reads 0 during reset
    always_comb begin
        bus.pvp_game_status       = status_q;
        bus.pvp_game_status_final = final_q;
        bus.p1_score              = p1_q;
        bus.p2_score              = p2_q;
        bus.round_num             = round_q;
        bus.match_point           = !general_reset && (state_q != MATCH_DONE) &&
                                    (p1_q == POINT_CNT || p2_q == POINT_CNT);
    end

endmodule

// File: tb/tb_pvp_match_tracker.sv
// Self-checking bench for pvp_match_tracker: directed match scenarios plus
// randomized rounds, compared against a rule-level scoreboard model.
module tb_pvp_match_tracker;

    localparam int WINS = 2;
    localparam int MAXR = 5;
    localparam int SW   = 3;

    logic clk = 1'b0;
    logic general_reset;

    always #5 clk = ~clk;

    pvp_match_tracker_if #(.SCORE_W(SW)) bus ();

    pvp_match_tracker #(
        .WINS_TO_MATCH(WINS),
        .MAX_ROUNDS   (MAXR),
        .SCORE_W      (SW)
    ) dut (
        .clk          (clk),
        .general_reset(general_reset),
        .bus          (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    int m_p1, m_p2, m_rounds, m_status, m_final;
    bit m_over, m_between;

    // Compare one observed value against the expected one
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ":status"}, 32'(bus.pvp_game_status), m_status);
        checkOutput({tag, ":final"},  32'(bus.pvp_game_status_final), m_final);
        checkOutput({tag, ":p1"},     32'(bus.p1_score), m_p1);
        checkOutput({tag, ":p2"},     32'(bus.p2_score), m_p2);
        checkOutput({tag, ":round"},  32'(bus.round_num), m_rounds);
        checkOutput({tag, ":mp"},     32'(bus.match_point),
                    (!m_over && (m_p1 == WINS - 1 || m_p2 == WINS - 1)) ? 1 : 0);
    endtask

    function automatic void modelClear();
        m_p1 = 0; m_p2 = 0; m_rounds = 0; m_status = 0; m_final = 0;
        m_over = 0; m_between = 0;
    endfunction

    // Match rules: a result counts only while a round is in play and no new-round strobe coincides
    function automatic void modelStep(input bit v, input int w, input bit g);
        if (m_over) return;
        if (m_between) begin
            if (g) begin
                m_status  = 0;
                m_between = 0;
            end
            return;
        end
        if (g || !v || w == 0) return;
        m_status = w;
        m_rounds++;
        if (w == 1) m_p1++;
        if (w == 2) m_p2++;
        if (m_p1 == WINS) begin
            m_final = 1; m_over = 1;
        end else if (m_p2 == WINS) begin
            m_final = 2; m_over = 1;
        end else if (m_rounds == MAXR) begin
            m_final = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
            m_over  = 1;
        end else begin
            m_between = 1;
        end
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, check after it
    task automatic applyStimulus(input bit v, input logic [1:0] w, input bit g,
                                 input string tag);
        @(negedge clk);
        bus.round_valid     = v;
        bus.round_winner    = w;
        bus.grid_reset_flag = g;
        @(posedge clk);
        modelStep(v, int'(w), g);
        #1;
        bus.round_valid     = 1'b0;
        bus.round_winner    = 2'b00;
        bus.grid_reset_flag = 1'b0;
        checkAll(tag);
    endtask

    task automatic playRound(input logic [1:0] w, input string tag);
        applyStimulus(1'b1, w, 1'b0, tag);
        applyStimulus(1'b0, 2'b00, 1'b1, {tag, "_grf"});
    endtask

    // Assert reset away from any clock edge and expect an immediate clear
    task automatic doReset(input string tag);
        @(negedge clk);
        #2;
        general_reset = 1'b1;
        modelClear();
        #1;
        checkAll({tag, "_async"});
        @(negedge clk);
        general_reset = 1'b0;
        #1;
        checkAll({tag, "_rel"});
    endtask

    initial begin
        bus.round_valid     = 1'b0;
        bus.round_winner    = 2'b00;
        bus.grid_reset_flag = 1'b0;
        general_reset       = 1'b1;
        modelClear();
        #12;
        checkAll("reset");
        @(negedge clk);
        general_reset = 1'b0;

        // P1 takes round 1, then P2 takes two rounds and the match
        applyStimulus(1'b1, 2'b01, 1'b0, "r1_p1");
        checkOutput("r1_status_const", 32'(bus.pvp_game_status), 1);
        checkOutput("r1_mp_const", 32'(bus.match_point), 1);
        applyStimulus(1'b0, 2'b00, 1'b1, "r1_grf");
        checkOutput("r1_grf_status_const", 32'(bus.pvp_game_status), 0);
        playRound(2'b10, "r2_p2");
        applyStimulus(1'b1, 2'b10, 1'b0, "r3_p2");
        checkOutput("r3_final_const", 32'(bus.pvp_game_status_final), 2);
        checkOutput("r3_p2_const", 32'(bus.p2_score), 2);
        checkOutput("r3_round_const", 32'(bus.round_num), 3);
        applyStimulus(1'b0, 2'b00, 1'b1, "done_grf");
        applyStimulus(1'b1, 2'b01, 1'b0, "done_valid");
        checkOutput("done_final_const", 32'(bus.pvp_game_status_final), 2);

        // Five draws hit the round cap
        doReset("rst_draws");
        for (int i = 0; i < 5; i++) playRound(2'b11, "draw");
        checkOutput("draws_final_const", 32'(bus.pvp_game_status_final), 3);
        checkOutput("draws_round_const", 32'(bus.round_num), 5);

        // Mixed runs ending on the cap
        doReset("rst_mix1");
        playRound(2'b01, "m1a"); playRound(2'b11, "m1b"); playRound(2'b11, "m1c");
        playRound(2'b10, "m1d"); playRound(2'b11, "m1e");
        checkOutput("mix1_final_const", 32'(bus.pvp_game_status_final), 3);
        doReset("rst_mix2");
        playRound(2'b01, "m2a"); playRound(2'b11, "m2b"); playRound(2'b11, "m2c");
        playRound(2'b11, "m2d"); playRound(2'b10, "m2e");
        checkOutput("mix2_final_const", 32'(bus.pvp_game_status_final), 3);
        doReset("rst_mix3");
        playRound(2'b01, "m3a"); playRound(2'b11, "m3b"); playRound(2'b11, "m3c");
        playRound(2'b11, "m3d"); playRound(2'b11, "m3e");
        checkOutput("mix3_final_const", 32'(bus.pvp_game_status_final), 1);

        // Ignored inputs, then async reset from a finished round at 1-0
        doReset("rst_ign");
        applyStimulus(1'b1, 2'b00, 1'b0, "ign_w00");
        applyStimulus(1'b1, 2'b01, 1'b1, "ign_coinc");
        applyStimulus(1'b1, 2'b01, 1'b0, "ign_p1");
        applyStimulus(1'b1, 2'b10, 1'b0, "ign_in_done");
        checkOutput("ign_p1_const", 32'(bus.p1_score), 1);
        doReset("rst_mid");
        applyStimulus(1'b1, 2'b10, 1'b0, "post_rst_p2");
        checkOutput("post_rst_p2_const", 32'(bus.p2_score), 1);
        checkOutput("post_rst_p1_const", 32'(bus.p1_score), 0);

        // Randomized traffic with occasional resets
        doReset("rst_rand");
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                doReset("rand_rst");
            end else begin
                applyStimulus(($urandom_range(0, 2) != 0),
                              2'($urandom_range(0, 3)),
                              ($urandom_range(0, 3) == 0),
                              "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
